// File: rtl/rf_sched_pkg.sv
// Shared constants and types for the register-file write scheduler.
package rf_sched_pkg;

    localparam int NREG_DEF = 16;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 16;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_e;

    typedef logic [NREG_DEF-1:0] busy_vec_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register outstanding-load scoreboard.
// Holds one busy bit per architectural register. A bit is set when a load
// is issued and cleared when that load returns. A same-cycle issue wins
// over a return, because the issue belongs to the newer load. Register 0
// and out-of-range addresses are never tracked. ld_err latches a return
// to a tracked register that had no outstanding load.
module rf_scoreboard
    import rf_sched_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_addr,
    input  logic          ld_fire,
    input  logic [AW-1:0] ld_addr,
    input  logic [AW-1:0] alu_addr,
    input  logic [AW-1:0] chk_addrA,
    input  logic [AW-1:0] chk_addrB,
    output logic          alu_busy,
    output logic          busy_a,
    output logic          busy_b,
    output logic          ld_err
);

    localparam int NSLOT = 2 ** AW;

    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_nxt;
    logic [NREG-1:0]  set_vec;
    logic [NREG-1:0]  clr_vec;
    logic [NSLOT-1:0] busy_ext;
    logic             err_hit;

    // Register 0 and addresses beyond the file are never tracked.
    function automatic logic writable(input logic [AW-1:0] a);
        writable = (a != '0) && ({1'b0, a} < (AW + 1)'(NREG));
    endfunction

    // Next busy vector: clear on load return, then set on issue so set wins.
    always_comb begin
        busy_ext = '0;
        busy_ext[NREG-1:0] = busy;
        if (iss_valid && writable(iss_addr)) begin
            set_vec = NREG'(1) << iss_addr;
        end else begin
            set_vec = '0;
        end
        if (ld_fire && writable(ld_addr)) begin
            clr_vec = NREG'(1) << ld_addr;
        end else begin
            clr_vec = '0;
        end
        busy_nxt = (busy & ~clr_vec) | set_vec;
        err_hit  = ld_fire && writable(ld_addr) && !busy_ext[ld_addr];
    end

    // Busy vector and sticky load-error flag.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            busy   <= '0;
            ld_err <= 1'b0;
        end else begin
            busy   <= busy_nxt;
            ld_err <= ld_err | err_hit;
        end
    end

    // Untracked addresses read back as not busy through the zero-extended view.
    assign alu_busy = busy_ext[alu_addr];
    assign busy_a   = busy_ext[chk_addrA];
    assign busy_b   = busy_ext[chk_addrB];

endmodule

// File: rtl/rf_write_sched.sv
// Register-file write-port scheduler.
// Arbitrates the single write port between the ALU result path and the
// load-return path (round-robin on ties), registers the write with one
// cycle of latency, and reports read hazards to decode.
// Optional feature macro: RF_BYPASS_EN adds byp_hitA/byp_hitB so decode can
// forward rf_wdata, and removes the uncommitted-write term from hazard.
module rf_write_sched
    import rf_sched_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_addr,
    input  logic [AW-1:0] chk_addrA,
    input  logic [AW-1:0] chk_addrB,
    output logic          hazard,
`ifdef RF_BYPASS_EN
    output logic          byp_hitA,
    output logic          byp_hitB,
`endif
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          ld_err
);

    req_e last_grant;
    logic alu_busy;
    logic busy_a;
    logic busy_b;
    logic alu_elig;
    logic grant_alu;
    logic grant_ld;
    logic hit_a;
    logic hit_b;

    // Register 0 and addresses beyond the file are accepted but never written.
    function automatic logic writable(input logic [AW-1:0] a);
        writable = (a != '0) && ({1'b0, a} < (AW + 1)'(NREG));
    endfunction

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .CLK       (CLK),
        .Reset     (Reset),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .ld_fire   (grant_ld),
        .ld_addr   (ld_addr),
        .alu_addr  (alu_addr),
        .chk_addrA (chk_addrA),
        .chk_addrB (chk_addrB),
        .alu_busy  (alu_busy),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .ld_err    (ld_err)
    );

    // An ALU write must wait behind an outstanding load to the same register.
    assign alu_elig = alu_valid && !alu_busy;

    // Grant selection: single eligible requester wins, ties alternate.
    always_comb begin
        grant_alu = 1'b0;
        grant_ld  = 1'b0;
        if (alu_elig && ld_valid) begin
            if (last_grant == REQ_LD) begin
                grant_alu = 1'b1;
            end else begin
                grant_ld = 1'b1;
            end
        end else if (alu_elig) begin
            grant_alu = 1'b1;
        end else if (ld_valid) begin
            grant_ld = 1'b1;
        end else begin
            grant_alu = 1'b0;
            grant_ld  = 1'b0;
        end
    end

    assign alu_ready = grant_alu;
    assign ld_ready  = grant_ld;

    // Round-robin pointer; moves only when something is granted.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            last_grant <= REQ_LD;
        end else if (grant_alu) begin
            last_grant <= REQ_ALU;
        end else if (grant_ld) begin
            last_grant <= REQ_LD;
        end else begin
            last_grant <= last_grant;
        end
    end

    // Registered write port; address/data hold whenever no write is issued.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_alu && writable(alu_addr)) begin
            rf_we    <= 1'b1;
            rf_waddr <= alu_addr;
            rf_wdata <= alu_data;
        end else if (grant_ld && writable(ld_addr)) begin
            rf_we    <= 1'b1;
            rf_waddr <= ld_addr;
            rf_wdata <= ld_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // A write sitting on the port has not reached the file yet.
    assign hit_a = rf_we && (rf_waddr != '0) && (rf_waddr == chk_addrA);
    assign hit_b = rf_we && (rf_waddr != '0) && (rf_waddr == chk_addrB);

`ifdef RF_BYPASS_EN
    assign byp_hitA = hit_a;
    assign byp_hitB = hit_b;
    assign hazard   = busy_a || busy_b;
`else
    assign hazard   = busy_a || busy_b || hit_a || hit_b;
`endif

endmodule

// File: doc/rf_write_sched.md
Name: rf_write_sched

Overview:
- Controller for the 16x16 register file's single write port.
- Arbitrates register writes between the ALU result path and the load-return path.
- Keeps a per-register scoreboard of outstanding loads, and flags read hazards to the decode/stall logic.
- Sits between execute/memory stages and the register file: it drives the file's write_en, waddr and data_in.

Parameters:
- NREG, 16, number of architectural registers tracked by the scoreboard
- AW, 5, register address width (matches register file pointer width)
- DW, 16, data width

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU write request
- alu_addr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- ld_valid  in  1  load-return write request
- ld_addr  in  AW  load destination register
- ld_data  in  DW  load data
- ld_ready  out  1  load request accepted this cycle
- iss_valid  in  1  load issued to memory (mark destination pending)
- iss_addr  in  AW  issued load's destination
- chk_addrA  in  AW  decode source A
- chk_addrB  in  AW  decode source B
- hazard  out  1  a source is pending or not yet committed
- rf_we  out  1  register file write_en
- rf_waddr  out  AW  register file waddr
- rf_wdata  out  DW  register file data_in
- ld_err  out  1  sticky: a load returned to a register that was not pending

Behaviour:
- Reset (async): rf_we=0, rf_waddr=0, rf_wdata=0, ld_err=0, all busy bits=0, last_grant=REQ_LD (so the ALU wins the first tie).
- Eligibility: ALU eligible = alu_valid && !busy[alu_addr]. This blocks WAW past an outstanding load. Load eligible = ld_valid.
- Arbitration (combinational ready):
  - One eligible requester: it is granted.
  - Both eligible: grant the requester not in last_grant (round-robin). last_grant updates only on a grant.
  - ready is high only in the granted cycle. A transfer occurs when valid && ready.
- Write port: registered, 1-cycle latency. The cycle after a transfer, rf_we=1 and rf_waddr/rf_wdata hold the granted addr/data.
  - No transfer: rf_we=0, rf_waddr/rf_wdata hold their last values.
- Address 0 and addresses >= NREG: the transfer is accepted (ready handshake completes) but rf_we stays 0. Their busy bits are never set.
- Scoreboard:
  - iss_valid sets busy[iss_addr], except for address 0 or addresses >= NREG.
  - A load transfer clears busy[ld_addr].
  - Set and clear of the same register in the same cycle: set wins (newer load).
- ld_err: set on a load transfer whose ld_addr is in range and nonzero but not busy. Cleared only by Reset.
- hazard (combinational): true when any of these holds:
  - busy[chk_addrA] is set;
  - busy[chk_addrB] is set;
  - rf_we && rf_waddr is nonzero && it equals chk_addrA or chk_addrB (write not yet committed).
- Reset mid-operation: all in-flight writes are dropped, busy is cleared, and no rf_we pulse follows Reset deassertion.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Adds outputs byp_hitA and byp_hitB (1 bit each). Each is asserted when rf_we && rf_waddr is nonzero && rf_waddr equals chk_addrA / chk_addrB respectively.
  - Decode muxes rf_wdata onto the matching source.
  - The uncommitted-write term is removed from hazard; only busy bits raise hazard.
- Undefined: no byp_* ports; hazard includes the uncommitted-write term as above.

Decomposition:
- Package rf_sched_pkg holds:
  - the constants NREG_DEF=16, AW_DEF=5, DW_DEF=16;
  - typedef enum logic {REQ_ALU, REQ_LD} req_e;
  - typedef logic [NREG_DEF-1:0] busy_vec_t.
- Sub-module rf_scoreboard contains the busy vector, the set/clear/priority logic, the two lookup ports and ld_err. Arbitration and the write-port register stay in the top level.

Test Plan:
- Reset mid-stream: assert Reset while a transfer is accepted -> rf_we=0 next cycle, busy=0, ld_err=0; the first tie after release grants the ALU.
- Tie / round-robin: alu_valid=ld_valid=1 for 4 cycles (addrs 3 and 5), busy clear -> grants ALU, LD, ALU, LD; rf_waddr sequence 3, 5, 3, 5 with 1-cycle lag.
- WAW block: iss_valid with iss_addr=7, then alu_valid with alu_addr=7 -> alu_ready=0 until the load with ld_addr=7 transfers. The ALU writes the cycle after that; rf_waddr=7 twice, load data first.
- Hazard: iss_addr=4, chk_addrA=4 -> hazard=1. Load returns 0xBEEF to r4 -> hazard stays 1 during the rf_we cycle (bypass off), then 0. With RF_BYPASS_EN: byp_hitA=1 and rf_wdata=0xBEEF in that cycle, hazard=0.
- Register 0 and set/clear collision:
  - ALU write to r0 with data 0x1234 -> alu_ready=1, rf_we stays 0.
  - iss_addr=6 in the same cycle as a ld_addr=6 transfer -> busy[6] remains 1.
- ld_err: load returns to r9 with no prior issue -> ld_err=1 and it stays 1 until Reset.
